// File: rtl/gcd_method_pkg.sv
// gcd_method shared definitions
// FSM state encoding and default sizing
package gcd_method_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_MAX_ITER = 1024;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/gcd_method_if.sv
// gcd method-call bus
// caller drives req/args, callee answers busy/result
interface gcd_method_if
  import gcd_method_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_req;
  logic             gcd_busy;
  logic [WIDTH-1:0] gcd_return;
  logic             gcd_error;
  logic [CNT_W-1:0] gcd_cycles;

  modport master (
    output gcd_a,
    output gcd_b,
    output gcd_req,
    input  gcd_busy,
    input  gcd_return,
    input  gcd_error,
    input  gcd_cycles
  );

  modport slave (
    input  gcd_a,
    input  gcd_b,
    input  gcd_req,
    output gcd_busy,
    output gcd_return,
    output gcd_error,
    output gcd_cycles
  );

endinterface

// File: rtl/gcd_method_step.sv
// one subtraction step of Euclid's algorithm
// larger operand is always the minuend, so no underflow
module gcd_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] next_x_o,
  output logic [WIDTH-1:0] next_y_o,
  output logic             finished_o,
  output logic [WIDTH-1:0] result_o
);

  logic x_zero;
  logic y_zero;
  logic x_gt_y;

  assign x_zero = (x_i == '0);
  assign y_zero = (y_i == '0);
  assign x_gt_y = (x_i > y_i);

  // terminal cases: a zero operand or equal operands
  always_comb begin
    finished_o = x_zero | y_zero | (x_i == y_i);
    result_o   = x_zero ? y_i : x_i;
  end

  // reduce the larger operand by the smaller one
  always_comb begin
    next_x_o = x_i;
    next_y_o = y_i;
    if (x_gt_y) begin
      next_x_o = x_i - y_i;
    end else begin
      next_y_o = y_i - x_i;
    end
  end

endmodule

// File: rtl/gcd_method.sv
// gcd method-call responder
// iterative subtraction with a step budget and error flag
module gcd_method
  import gcd_method_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic         clk,
  input logic         reset,
  gcd_method_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] ret_q, ret_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic [WIDTH-1:0] nx;
  logic [WIDTH-1:0] ny;
  logic             fin;
  logic [WIDTH-1:0] res;
  logic             budget_hit;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .x_i        (x_q),
    .y_i        (y_q),
    .next_x_o   (nx),
    .next_y_o   (ny),
    .finished_o (fin),
    .result_o   (res)
  );

  assign budget_hit = (cnt_q == CNT_W'(MAX_ITER));

  // state and datapath registers; busy reads high while in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      ret_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  // call sequencing: accept, iterate, publish, wait for req release
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ret_d   = ret_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      ST_INIT: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.gcd_req) begin
          x_d     = bus.gcd_a;
          y_d     = bus.gcd_b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (fin) begin
          ret_d   = res;
          cyc_d   = cnt_q;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (budget_hit) begin
          ret_d   = '0;
          err_d   = 1'b1;
          cyc_d   = cnt_q;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          x_d   = nx;
          y_d   = ny;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!bus.gcd_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign bus.gcd_busy   = busy_q;
  assign bus.gcd_return = ret_q;
  assign bus.gcd_error  = err_q;
  assign bus.gcd_cycles = cyc_q;

endmodule

// File: tb/tb_gcd_method.sv
// gcd_method bench: vector table plus scoreboard queue
// small step budget so exhaustion is reachable
module tb_gcd_method;

  localparam int W    = 32;
  localparam int CW   = 16;
  localparam int MAXI = 8;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  ret;
    logic [CW-1:0] cyc;
    logic          err;
    logic          hold;
  } vec_t;

  typedef struct {
    logic [W-1:0]  ret;
    logic [CW-1:0] cyc;
    logic          err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [W-1:0] last_ret;
  exp_t sb[$];
  vec_t tv[$];

  gcd_method_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  gcd_method #(
    .WIDTH    (W),
    .MAX_ITER (MAXI),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic run_call(input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.gcd_req = 1'b0;
    @(negedge clk);
    bus.gcd_a   = v.a;
    bus.gcd_b   = v.b;
    bus.gcd_req = 1'b1;
    e.ret = v.ret;
    e.cyc = v.cyc;
    e.err = v.err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("busy_at_accept", W'(bus.gcd_busy), 1);
    check("err_clr_accept", W'(bus.gcd_error), 0);
    check("ret_held_accept", bus.gcd_return, last_ret);
    bus.gcd_a = $urandom;
    bus.gcd_b = $urandom;
    if (!v.hold) bus.gcd_req = 1'b0;
    n = 0;
    while (bus.gcd_busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got %0d want <100", n);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got 0 want 1");
    end else begin
      e = sb.pop_front();
      check("return", bus.gcd_return, e.ret);
      check("cycles", W'(bus.gcd_cycles), W'(e.cyc));
      check("error", W'(bus.gcd_error), W'(e.err));
      check("busy_len", W'(n), W'(e.cyc) + 1);
      last_ret = e.ret;
    end
    if (v.hold) begin
      repeat (2) @(posedge clk);
      #1;
      check("no_retrigger", W'(bus.gcd_busy), 0);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    last_ret    = '0;
    reset       = 1'b1;
    bus.gcd_req = 1'b0;
    bus.gcd_a   = '0;
    bus.gcd_b   = '0;

    tv.push_back('{32'd12, 32'd18, 32'd6, 16'd2, 1'b0, 1'b1});
    tv.push_back('{32'd0, 32'd7, 32'd7, 16'd0, 1'b0, 1'b0});
    tv.push_back('{32'd9, 32'd0, 32'd9, 16'd0, 1'b0, 1'b0});
    tv.push_back('{32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0});
    tv.push_back('{32'd5, 32'd5, 32'd5, 16'd0, 1'b0, 1'b1});
    tv.push_back('{32'd1, 32'd100, 32'd0, 16'd8, 1'b1, 1'b0});
    tv.push_back('{32'd1, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0});
    tv.push_back('{32'd48, 32'd36, 32'd12, 16'd3, 1'b0, 1'b0});
    tv.push_back('{32'd17, 32'd5, 32'd1, 16'd6, 1'b0, 1'b0});
    tv.push_back('{32'd7, 32'd1, 32'd1, 16'd6, 1'b0, 1'b1});
    tv.push_back('{32'd1, 32'd9, 32'd1, 16'd8, 1'b0, 1'b0});
    tv.push_back('{32'd1, 32'd10, 32'd0, 16'd8, 1'b1, 1'b0});
    tv.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE,
                   32'd0, 16'd8, 1'b1, 1'b0});

    repeat (2) @(negedge clk);
    check("rst_busy", W'(bus.gcd_busy), 1);
    check("rst_ret", bus.gcd_return, 0);
    check("rst_err", W'(bus.gcd_error), 0);
    check("rst_cyc", W'(bus.gcd_cycles), 0);
    reset = 1'b0;
    @(negedge clk);
    check("init_busy", W'(bus.gcd_busy), 0);

    foreach (tv[i]) run_call(tv[i]);

    @(negedge clk);
    bus.gcd_req = 1'b0;
    @(negedge clk);
    bus.gcd_a   = 32'd1000;
    bus.gcd_b   = 32'd3;
    bus.gcd_req = 1'b1;
    @(posedge clk);
    #1;
    bus.gcd_req = 1'b0;
    check("mid_busy", W'(bus.gcd_busy), 1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", W'(bus.gcd_busy), 1);
    check("arst_ret", bus.gcd_return, 0);
    check("arst_err", W'(bus.gcd_error), 0);
    check("arst_cyc", W'(bus.gcd_cycles), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", W'(bus.gcd_busy), 0);
    check("post_rst_ret", bus.gcd_return, 0);
    last_ret = '0;
    run_call('{32'd21, 32'd14, 32'd7, 16'd2, 1'b0, 1'b0});

    check("sb_drained", W'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

endmodule
